tl_buffer: RTL and testbench

Two-channel TileLink-UL buffer that sits directly downstream of the 64-bit width widget on the peripheral path, between the width widget's `auto_out` port and the fragmenter/crossbar beyond it. It inserts a registered FIFO on the A channel and, optionally, on the D channel. This breaks the combinational ready/valid/data paths between the width widget and the next node, with full 1-beat/cycle throughput. Field widths match the width widget's ports exactly, so the block drops in with no adapters.

---
 rtl/tl_pkg.sv | 38 +++
 rtl/tl_queue.sv | 73 +++++++
 rtl/tl_buffer.sv | 137 +++++++++++++
 tb/tb_tl_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL field widths and packed beat bundles for the peripheral-path buffer.
package tl_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned SIZE_W     = 4;
    localparam int unsigned SOURCE_W   = 1;
    localparam int unsigned SINK_W     = 3;
    localparam int unsigned MASK_W     = 8;
    localparam int unsigned OPCODE_W   = 3;
    localparam int unsigned A_PARAM_W  = 3;
    localparam int unsigned D_PARAM_W  = 2;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [A_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [SOURCE_W-1:0]  source;
        logic [ADDR_W-1:0]    address;
        logic [MASK_W-1:0]    mask;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } tl_a_bits_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [D_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [SINK_W-1:0]    sink;
        logic                 denied;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } tl_d_bits_t;

    localparam int unsigned A_BITS_W = $bits(tl_a_bits_t);
    localparam int unsigned D_BITS_W = $bits(tl_d_bits_t);

endpackage

// File: rtl/tl_queue.sv
// Registered circular FIFO for one TileLink channel; ready and valid depend only on the
// occupancy register, so no combinational path crosses the queue.
module tl_queue
    import tl_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = tl_a_bits_t
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_bits,
    output logic out_valid,
    input  logic out_ready,
    output T     out_bits
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    T                 storage_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq, deq;

    // A full queue refuses input even while draining: no ready pass-through.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign out_bits  = storage_q[rd_ptr_q];

    assign enq = in_valid & in_ready;
    assign deq = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                storage_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq) begin
                storage_q[wr_ptr_q] <= in_bits;
            end
        end
    end

endmodule

// File: rtl/tl_buffer.sv
// TileLink-UL buffer behind the 64-bit width widget: A is always queued, D is queued only
// when TL_BUFFER_D_QUEUE_EN is defined and is otherwise a straight wire-through.
module tl_buffer
    import tl_pkg::*;
#(
    parameter int unsigned A_DEPTH = 2,
    parameter int unsigned D_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 auto_in_a_valid,
    output logic                 auto_in_a_ready,
    input  logic [OPCODE_W-1:0]  auto_in_a_bits_opcode,
    input  logic [A_PARAM_W-1:0] auto_in_a_bits_param,
    input  logic [SIZE_W-1:0]    auto_in_a_bits_size,
    input  logic [SOURCE_W-1:0]  auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]    auto_in_a_bits_address,
    input  logic [MASK_W-1:0]    auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]    auto_in_a_bits_data,
    input  logic                 auto_in_a_bits_corrupt,

    output logic                 auto_out_a_valid,
    input  logic                 auto_out_a_ready,
    output logic [OPCODE_W-1:0]  auto_out_a_bits_opcode,
    output logic [A_PARAM_W-1:0] auto_out_a_bits_param,
    output logic [SIZE_W-1:0]    auto_out_a_bits_size,
    output logic [SOURCE_W-1:0]  auto_out_a_bits_source,
    output logic [ADDR_W-1:0]    auto_out_a_bits_address,
    output logic [MASK_W-1:0]    auto_out_a_bits_mask,
    output logic [DATA_W-1:0]    auto_out_a_bits_data,
    output logic                 auto_out_a_bits_corrupt,

    input  logic                 auto_out_d_valid,
    output logic                 auto_out_d_ready,
    input  logic [OPCODE_W-1:0]  auto_out_d_bits_opcode,
    input  logic [D_PARAM_W-1:0] auto_out_d_bits_param,
    input  logic [SIZE_W-1:0]    auto_out_d_bits_size,
    input  logic [SINK_W-1:0]    auto_out_d_bits_sink,
    input  logic                 auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]    auto_out_d_bits_data,
    input  logic                 auto_out_d_bits_corrupt,

    output logic                 auto_in_d_valid,
    input  logic                 auto_in_d_ready,
    output logic [OPCODE_W-1:0]  auto_in_d_bits_opcode,
    output logic [D_PARAM_W-1:0] auto_in_d_bits_param,
    output logic [SIZE_W-1:0]    auto_in_d_bits_size,
    output logic [SINK_W-1:0]    auto_in_d_bits_sink,
    output logic                 auto_in_d_bits_denied,
    output logic [DATA_W-1:0]    auto_in_d_bits_data,
    output logic                 auto_in_d_bits_corrupt
);

    tl_a_bits_t a_in_bits, a_out_bits;
    tl_d_bits_t d_in_bits, d_out_bits;

    if (A_DEPTH == 0 || D_DEPTH == 0) begin : g_depth_check
        $error("tl_buffer: A_DEPTH and D_DEPTH must be at least 1");
    end

    always_comb begin
        a_in_bits         = '0;
        a_in_bits.opcode  = auto_in_a_bits_opcode;
        a_in_bits.param   = auto_in_a_bits_param;
        a_in_bits.size    = auto_in_a_bits_size;
        a_in_bits.source  = auto_in_a_bits_source;
        a_in_bits.address = auto_in_a_bits_address;
        a_in_bits.mask    = auto_in_a_bits_mask;
        a_in_bits.data    = auto_in_a_bits_data;
        a_in_bits.corrupt = auto_in_a_bits_corrupt;
    end

    tl_queue #(
        .DEPTH (A_DEPTH),
        .T     (tl_a_bits_t)
    ) u_a_queue (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (auto_in_a_valid),
        .in_ready  (auto_in_a_ready),
        .in_bits   (a_in_bits),
        .out_valid (auto_out_a_valid),
        .out_ready (auto_out_a_ready),
        .out_bits  (a_out_bits)
    );

    assign auto_out_a_bits_opcode  = a_out_bits.opcode;
    assign auto_out_a_bits_param   = a_out_bits.param;
    assign auto_out_a_bits_size    = a_out_bits.size;
    assign auto_out_a_bits_source  = a_out_bits.source;
    assign auto_out_a_bits_address = a_out_bits.address;
    assign auto_out_a_bits_mask    = a_out_bits.mask;
    assign auto_out_a_bits_data    = a_out_bits.data;
    assign auto_out_a_bits_corrupt = a_out_bits.corrupt;

    always_comb begin
        d_in_bits         = '0;
        d_in_bits.opcode  = auto_out_d_bits_opcode;
        d_in_bits.param   = auto_out_d_bits_param;
        d_in_bits.size    = auto_out_d_bits_size;
        d_in_bits.sink    = auto_out_d_bits_sink;
        d_in_bits.denied  = auto_out_d_bits_denied;
        d_in_bits.data    = auto_out_d_bits_data;
        d_in_bits.corrupt = auto_out_d_bits_corrupt;
    end

`ifdef TL_BUFFER_D_QUEUE_EN
    tl_queue #(
        .DEPTH (D_DEPTH),
        .T     (tl_d_bits_t)
    ) u_d_queue (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (auto_out_d_valid),
        .in_ready  (auto_out_d_ready),
        .in_bits   (d_in_bits),
        .out_valid (auto_in_d_valid),
        .out_ready (auto_in_d_ready),
        .out_bits  (d_out_bits)
    );
`else
    // Zero-latency D path: the response handshake is forwarded untouched.
    assign auto_in_d_valid  = auto_out_d_valid;
    assign auto_out_d_ready = auto_in_d_ready;
    assign d_out_bits       = d_in_bits;
`endif

    assign auto_in_d_bits_opcode  = d_out_bits.opcode;
    assign auto_in_d_bits_param   = d_out_bits.param;
    assign auto_in_d_bits_size    = d_out_bits.size;
    assign auto_in_d_bits_sink    = d_out_bits.sink;
    assign auto_in_d_bits_denied  = d_out_bits.denied;
    assign auto_in_d_bits_data    = d_out_bits.data;
    assign auto_in_d_bits_corrupt = d_out_bits.corrupt;

endmodule

// File: tb/tb_tl_buffer.sv
// Directed and randomised checks of tl_buffer A queueing and the D path (queued or wired,
// following TL_BUFFER_D_QUEUE_EN).
module tb_tl_buffer;

    localparam int unsigned A_DEPTH = 2;
    localparam int unsigned D_DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        auto_in_a_valid, auto_in_a_ready;
    logic [2:0]  auto_in_a_bits_opcode, auto_in_a_bits_param;
    logic [3:0]  auto_in_a_bits_size;
    logic        auto_in_a_bits_source;
    logic [31:0] auto_in_a_bits_address;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_a_bits_corrupt;

    logic        auto_out_a_valid, auto_out_a_ready;
    logic [2:0]  auto_out_a_bits_opcode, auto_out_a_bits_param;
    logic [3:0]  auto_out_a_bits_size;
    logic        auto_out_a_bits_source;
    logic [31:0] auto_out_a_bits_address;
    logic [7:0]  auto_out_a_bits_mask;
    logic [63:0] auto_out_a_bits_data;
    logic        auto_out_a_bits_corrupt;

    logic        auto_out_d_valid, auto_out_d_ready;
    logic [2:0]  auto_out_d_bits_opcode;
    logic [1:0]  auto_out_d_bits_param;
    logic [3:0]  auto_out_d_bits_size;
    logic [2:0]  auto_out_d_bits_sink;
    logic        auto_out_d_bits_denied;
    logic [63:0] auto_out_d_bits_data;
    logic        auto_out_d_bits_corrupt;

    logic        auto_in_d_valid, auto_in_d_ready;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [1:0]  auto_in_d_bits_param;
    logic [3:0]  auto_in_d_bits_size;
    logic [2:0]  auto_in_d_bits_sink;
    logic        auto_in_d_bits_denied;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_corrupt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [115:0] out_a_word;
    logic [77:0]  in_d_word;
    assign out_a_word = {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
                         auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
                         auto_out_a_bits_data, auto_out_a_bits_corrupt};
    assign in_d_word  = {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
                         auto_in_d_bits_sink, auto_in_d_bits_denied, auto_in_d_bits_data,
                         auto_in_d_bits_corrupt};

    always #5 clock = ~clock;

    tl_buffer #(
        .A_DEPTH (A_DEPTH),
        .D_DEPTH (D_DEPTH)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .auto_in_a_valid         (auto_in_a_valid),
        .auto_in_a_ready         (auto_in_a_ready),
        .auto_in_a_bits_opcode   (auto_in_a_bits_opcode),
        .auto_in_a_bits_param    (auto_in_a_bits_param),
        .auto_in_a_bits_size     (auto_in_a_bits_size),
        .auto_in_a_bits_source   (auto_in_a_bits_source),
        .auto_in_a_bits_address  (auto_in_a_bits_address),
        .auto_in_a_bits_mask     (auto_in_a_bits_mask),
        .auto_in_a_bits_data     (auto_in_a_bits_data),
        .auto_in_a_bits_corrupt  (auto_in_a_bits_corrupt),
        .auto_out_a_valid        (auto_out_a_valid),
        .auto_out_a_ready        (auto_out_a_ready),
        .auto_out_a_bits_opcode  (auto_out_a_bits_opcode),
        .auto_out_a_bits_param   (auto_out_a_bits_param),
        .auto_out_a_bits_size    (auto_out_a_bits_size),
        .auto_out_a_bits_source  (auto_out_a_bits_source),
        .auto_out_a_bits_address (auto_out_a_bits_address),
        .auto_out_a_bits_mask    (auto_out_a_bits_mask),
        .auto_out_a_bits_data    (auto_out_a_bits_data),
        .auto_out_a_bits_corrupt (auto_out_a_bits_corrupt),
        .auto_out_d_valid        (auto_out_d_valid),
        .auto_out_d_ready        (auto_out_d_ready),
        .auto_out_d_bits_opcode  (auto_out_d_bits_opcode),
        .auto_out_d_bits_param   (auto_out_d_bits_param),
        .auto_out_d_bits_size    (auto_out_d_bits_size),
        .auto_out_d_bits_sink    (auto_out_d_bits_sink),
        .auto_out_d_bits_denied  (auto_out_d_bits_denied),
        .auto_out_d_bits_data    (auto_out_d_bits_data),
        .auto_out_d_bits_corrupt (auto_out_d_bits_corrupt),
        .auto_in_d_valid         (auto_in_d_valid),
        .auto_in_d_ready         (auto_in_d_ready),
        .auto_in_d_bits_opcode   (auto_in_d_bits_opcode),
        .auto_in_d_bits_param    (auto_in_d_bits_param),
        .auto_in_d_bits_size     (auto_in_d_bits_size),
        .auto_in_d_bits_sink     (auto_in_d_bits_sink),
        .auto_in_d_bits_denied   (auto_in_d_bits_denied),
        .auto_in_d_bits_data     (auto_in_d_bits_data),
        .auto_in_d_bits_corrupt  (auto_in_d_bits_corrupt)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input logic [115:0] w);
        {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
         auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
         auto_in_a_bits_data, auto_in_a_bits_corrupt} = w;
    endtask

    task automatic set_d(input logic [77:0] w);
        {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
         auto_out_d_bits_sink, auto_out_d_bits_denied, auto_out_d_bits_data,
         auto_out_d_bits_corrupt} = w;
    endtask

    function automatic logic [115:0] rand_a();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[115:0];
    endfunction

    function automatic logic [77:0] rand_d();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[77:0];
    endfunction

    logic [115:0] get_beat, b0, b1, b2, cur;
    logic [115:0] a_beats [100];
    logic [77:0]  d_beats [100];
    logic [77:0]  d_probe;
    logic [115:0] model_q [$];
    int           drain;

    initial begin
        auto_in_a_valid  = 1'b0;
        auto_out_a_ready = 1'b0;
        auto_out_d_valid = 1'b0;
        auto_in_d_ready  = 1'b1;
        set_a('0);
        set_d('0);

        // Reset and idle state
        step();
        step();
        reset = 1'b1;
        check_eq("rst_out_a_valid", auto_out_a_valid, 1'b0);
        check_eq("rst_in_a_ready", auto_in_a_ready, 1'b1);
        check_eq("rst_out_a_bits", out_a_word, '0);
        check_eq("rst_in_d_valid", auto_in_d_valid, 1'b0);
        check_eq("rst_out_d_ready", auto_out_d_ready, 1'b1);
        check_eq("rst_in_d_bits", in_d_word, '0);

        // Single Get beat: no flow-through, visible one cycle later
        get_beat = {3'd4, 3'd0, 4'd3, 1'b0, 32'h8000_0000, 8'hFF, 64'h0, 1'b0};
        set_a(get_beat);
        auto_in_a_valid = 1'b1;
        check_eq("single_no_flow", auto_out_a_valid, 1'b0);
        step();
        auto_in_a_valid = 1'b0;
        set_a('0);
        check_eq("single_valid", auto_out_a_valid, 1'b1);
        check_eq("single_bits", out_a_word, get_beat);
        auto_out_a_ready = 1'b1;
        step();
        check_eq("single_drained", auto_out_a_valid, 1'b0);

        // Backpressure with A_DEPTH=2
        auto_out_a_ready = 1'b0;
        b0 = rand_a();
        b1 = rand_a();
        b2 = rand_a();
        set_a(b0);
        auto_in_a_valid = 1'b1;
        check_eq("bp_ready0", auto_in_a_ready, 1'b1);
        step();
        set_a(b1);
        check_eq("bp_ready1", auto_in_a_ready, 1'b1);
        step();
        set_a(b2);
        check_eq("bp_full", auto_in_a_ready, 1'b0);
        step();
        check_eq("bp_still_full", auto_in_a_ready, 1'b0);
        check_eq("bp_head", out_a_word, b0);
        auto_out_a_ready = 1'b1;
        check_eq("bp_no_passthru", auto_in_a_ready, 1'b0);
        step();
        check_eq("bp_ready_after_deq", auto_in_a_ready, 1'b1);
        check_eq("bp_second", out_a_word, b1);
        step();
        auto_in_a_valid = 1'b0;
        check_eq("bp_third_valid", auto_out_a_valid, 1'b1);
        check_eq("bp_third", out_a_word, b2);
        step();
        check_eq("bp_empty", auto_out_a_valid, 1'b0);

        // Mid-stream reset discards queued beats
        auto_out_a_ready = 1'b0;
        auto_in_a_valid  = 1'b1;
        set_a(rand_a());
        step();
        set_a(rand_a());
        step();
        auto_in_a_valid = 1'b0;
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        check_eq("mrst_valid", auto_out_a_valid, 1'b0);
        check_eq("mrst_ready", auto_in_a_ready, 1'b1);
        check_eq("mrst_bits", out_a_word, '0);
        b0 = rand_a();
        set_a(b0);
        auto_in_a_valid = 1'b1;
        step();
        auto_in_a_valid  = 1'b0;
        auto_out_a_ready = 1'b1;
        check_eq("mrst_first_beat", out_a_word, b0);
        step();
        check_eq("mrst_drained", auto_out_a_valid, 1'b0);

`ifndef TL_BUFFER_D_QUEUE_EN
        // Wired D path: same-cycle visibility and ready mirroring
        d_probe = {3'd1, 2'd0, 4'd3, 3'd0, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0};
        set_d(d_probe);
        auto_out_d_valid = 1'b1;
        #1;
        check_eq("dwire_valid", auto_in_d_valid, 1'b1);
        check_eq("dwire_bits", in_d_word, d_probe);
        auto_in_d_ready = 1'b0;
        #1;
        check_eq("dwire_ready0", auto_out_d_ready, 1'b0);
        auto_in_d_ready = 1'b1;
        #1;
        check_eq("dwire_ready1", auto_out_d_ready, 1'b1);
        auto_out_d_valid = 1'b0;
        step();
`endif

        // Streaming 100 beats on A and D with readys held high
        auto_out_a_ready = 1'b1;
        auto_in_d_ready  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_beats[i] = rand_a();
            d_beats[i] = rand_d();
            set_a(a_beats[i]);
            set_d(d_beats[i]);
            auto_in_a_valid  = 1'b1;
            auto_out_d_valid = 1'b1;
            #1;
            check_eq("stream_a_ready", auto_in_a_ready, 1'b1);
            check_eq("stream_a_valid", auto_out_a_valid, (i > 0));
            if (i > 0) check_eq("stream_a_bits", out_a_word, a_beats[i-1]);
`ifdef TL_BUFFER_D_QUEUE_EN
            check_eq("stream_d_valid", auto_in_d_valid, (i > 0));
            if (i > 0) check_eq("stream_d_bits", in_d_word, d_beats[i-1]);
`else
            check_eq("stream_d_valid", auto_in_d_valid, 1'b1);
            check_eq("stream_d_bits", in_d_word, d_beats[i]);
`endif
            step();
        end
        auto_in_a_valid  = 1'b0;
        auto_out_d_valid = 1'b0;
        check_eq("stream_a_last", out_a_word, a_beats[99]);
`ifdef TL_BUFFER_D_QUEUE_EN
        check_eq("stream_d_last", in_d_word, d_beats[99]);
`endif
        step();
        check_eq("stream_a_empty", auto_out_a_valid, 1'b0);

        // Random valid/ready toggling against a reference queue
        cur = rand_a();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic do_enq, do_deq;
            auto_in_a_valid  = 1'($urandom_range(0, 1));
            auto_out_a_ready = 1'($urandom_range(0, 1));
            set_a(cur);
            #1;
            check_eq("rnd_in_ready", auto_in_a_ready, (model_q.size() != int'(A_DEPTH)));
            check_eq("rnd_out_valid", auto_out_a_valid, (model_q.size() != 0));
            do_deq = auto_out_a_ready && (model_q.size() != 0);
            do_enq = auto_in_a_valid && (model_q.size() < int'(A_DEPTH));
            if (do_deq) begin
                check_eq("rnd_bits", out_a_word, model_q[0]);
                void'(model_q.pop_front());
            end
            if (do_enq) begin
                model_q.push_back(cur);
                cur = rand_a();
            end
            step();
        end
        auto_in_a_valid  = 1'b0;
        auto_out_a_ready = 1'b1;
        drain = 0;
        while (model_q.size() != 0 && drain < 10) begin
            check_eq("drain_bits", out_a_word, model_q[0]);
            void'(model_q.pop_front());
            step();
            drain++;
        end
        check_eq("drain_empty", auto_out_a_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
